grid_line_clear_seq: RTL and testbench
======================================

# grid_line_clear_seq

Line-clear sequencer for the Tetris playfield. It takes ownership of the row-addressed grid RAM after a piece locks, scans the rows bottom-up, removes every full row by compacting the remaining rows downward, and zero-fills the vacated top rows. It then reports how many lines were cleared. It sits between the piece-drop/lock logic, which issues `start`, and the grid RAM; the parent uses `busy` to steer the RAM ports to this block.

## Interface
Parameters:
- `ROWS`, 16, playfield height; row 0 is the top, row ROWS-1 is the bottom.
- `COLS`, 16, playfield width; one RAM word is one row.
- `AW`, $clog2(ROWS), row address width.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a clear pass; accepted only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle; the grid ports belong to this block while it is high.
- `done`  out  1  one-cycle pulse at the end of a pass.
- `lines_cleared`  out  $clog2(ROWS+1)  number of full rows removed in the last pass; held until the next accepted `start`.
- `rd_addr`  out  AW  grid RAM read address.
- `rd_data`  in  COLS  grid RAM read data; synchronous, valid 1 cycle after `rd_addr`.
- `wr_en`  out  1  grid RAM write enable.
- `wr_addr`  out  AW  grid RAM write address.
- `wr_data`  out  COLS  grid RAM write data.

## Operation
- Registers:
  - `src` (AW bits): read pointer.
  - `dst` (AW+1 bits): write pointer; MSB set means underflow.
  - `cnt`: lines-cleared counter.
  - `state`.
- States are IDLE, READ, EVAL, FILL and DONE.
- IDLE: on `start`, load `src`=ROWS-1, `dst`=ROWS-1, `cnt`=0, then go to READ.
- READ: drive `rd_addr`=`src`, then go to EVAL.
- EVAL examines `rd_data`:
  - All ones (`&rd_data`): `cnt`++ and no write.
  - Otherwise: if `src`≠`dst`, write `rd_data` to `dst`; if `src`=`dst`, no write (no redundant write). In both cases `dst`--.
  - Then if `src`=0, go to FILL when `cnt`≠0, else go to DONE. Otherwise `src`-- and go to READ.
- FILL: write `wr_data`=0 at `dst`, then `dst`--. Stay in FILL until the row written was row 0, then go to DONE. Exactly `cnt` rows are written.
- DONE: `done`=1, `lines_cleared`←`cnt`, then go to IDLE.
- Outputs are idle-low: `wr_en`=0 and `wr_data`=0 in every state other than EVAL (write case) and FILL.
- `start` is ignored while `busy`=1; there is no queueing.
- `rd_data` is treated as garbage outside EVAL.

## Timing
- Reset values: `busy`=0, `done`=0, `lines_cleared`=0, `wr_en`=0, `rd_addr`=0, `wr_addr`=0, `wr_data`=0, state=IDLE.
- Let edge 0 be the `start`-accept edge. Then:
  - `busy` rises after edge 0.
  - READ/EVAL occupy 2·ROWS cycles.
  - FILL occupies `cnt` cycles.
  - DONE occupies 1 cycle.
  - `done` is high in cycle 2·ROWS+`cnt`+1. For ROWS=16: cycle 33 with no clears, cycle 49 with 16 clears.
- `busy` falls together with `done` at the edge leaving DONE. A new `start` is accepted on the first IDLE cycle after that.
- Write outputs are registered. A write for row r appears at most 1 cycle after its EVAL decision.
- `rd_addr` follows the `src` register with no bubbles.
- Reset mid-pass: the next edge goes to IDLE and all outputs return to their reset values. Grid contents may be partially compacted; the parent must reinitialise the grid.
- `cnt` cannot overflow: its maximum is ROWS, which fits in $clog2(ROWS+1) bits.

## Structure
- Shared package `tetris_pkg`:
  - `GRID_ROWS` and `GRID_COLS` constants.
  - `row_t` (`logic [GRID_COLS-1:0]`).
  - `clr_state_t` enum (IDLE, READ, EVAL, FILL, DONE).
- No RTL sub-module is needed; the full-row detect is a single reduction AND.
- Testbench-only model `grid_row_ram`: ROWS×COLS, one sync read port and one write port, read latency 1.

## Test plan
- Empty grid, `start` pulse → `done` at cycle 33, `lines_cleared`=0, zero writes issued.
- Row 15 full, row 14=16'h0001, rest 0 → row 15=16'h0001, rows 0–14=0, `lines_cleared`=1, `done` at cycle 34.
- Rows 15 and 13 full, row 14=16'h00F0, row 12=16'h0F00 → row 15=16'h00F0, row 14=16'h0F00, rows 0–13=0, `lines_cleared`=2.
- All 16 rows full → 0 EVAL writes, 16 FILL writes of 0, `lines_cleared`=16, `done` at cycle 49.
- `start` held high through an entire pass → exactly one pass runs; a second pass begins only on the cycle after `done`, and `lines_cleared` holds its value until then.
- `reset` asserted on cycle 10 of a pass → next cycle `busy`=0, `wr_en`=0, `lines_cleared`=0; a subsequent `start` completes normally.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield definitions for the Tetris grid blocks.
package tetris_pkg;
  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;

  typedef logic [GRID_COLS-1:0] row_t;

  typedef enum logic [2:0] {IDLE, READ, EVAL, FILL, DONE} clr_state_t;
endpackage

// File: rtl/grid_line_clear_seq_if.sv
// Row-addressed grid RAM port: one sync read port (latency 1), one write port.
interface grid_line_clear_seq_if #(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int AW   = $clog2(ROWS)
);
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;

  modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
  modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/grid_line_clear_seq.sv
// Line-clear sequencer: bottom-up scan, compacts non-full rows downward,
// zero-fills the vacated top rows and reports the number of rows removed.
module grid_line_clear_seq
  import tetris_pkg::*;
#(
  parameter int ROWS = GRID_ROWS,
  parameter int COLS = GRID_COLS,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  grid_line_clear_seq_if.master      grid
);
  localparam int CW = $clog2(ROWS+1);

  clr_state_t      state, state_nxt;
  logic [AW-1:0]   src, src_nxt;
  logic [AW:0]     dst, dst_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            wr_en_nxt;
  logic [AW-1:0]   wr_addr_nxt;
  logic [COLS-1:0] wr_data_nxt;
  logic            row_full;

  assign row_full     = &grid.rd_data;
  assign grid.rd_addr = src;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      src           <= '0;
      dst           <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      grid.wr_en    <= 1'b0;
      grid.wr_addr  <= '0;
      grid.wr_data  <= '0;
    end else begin
      state        <= state_nxt;
      src          <= src_nxt;
      dst          <= dst_nxt;
      cnt          <= cnt_nxt;
      grid.wr_en   <= wr_en_nxt;
      grid.wr_addr <= wr_addr_nxt;
      grid.wr_data <= wr_data_nxt;
      if (state == DONE) lines_cleared <= cnt;
    end
  end

  always_comb begin
    state_nxt   = state;
    src_nxt     = src;
    dst_nxt     = dst;
    cnt_nxt     = cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = '0;
    wr_data_nxt = '0;
    case (state)
      IDLE: begin
        if (start) begin
          src_nxt   = AW'(ROWS-1);
          dst_nxt   = (AW+1)'(ROWS-1);
          cnt_nxt   = '0;
          state_nxt = READ;
        end
      end
      READ: state_nxt = EVAL;
      EVAL: begin
        if (row_full) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          // A row that has not moved yet is already in place; skip the write.
          if ({1'b0, src} != dst) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = dst[AW-1:0];
            wr_data_nxt = grid.rd_data;
          end
          dst_nxt = dst - 1'b1;
        end
        if (src == '0) begin
          state_nxt = (cnt_nxt != '0) ? FILL : DONE;
        end else begin
          src_nxt   = src - 1'b1;
          state_nxt = READ;
        end
      end
      FILL: begin
        // dst enters FILL at cnt-1, so exactly cnt zero rows are written.
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = dst[AW-1:0];
        dst_nxt     = dst - 1'b1;
        if (dst[AW-1:0] == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_grid_line_clear_seq.sv
// Directed bench for grid_line_clear_seq with a behavioural grid RAM and a write scoreboard.
module tb_grid_line_clear_seq;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int AW   = 4;
  localparam int CW   = 5;

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [COLS-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic [CW-1:0] lines_cleared;

  grid_line_clear_seq_if #(.ROWS(ROWS), .COLS(COLS)) g ();

  grid_line_clear_seq #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .grid(g)
  );

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic [COLS-1:0] exp_img [ROWS];
  logic            ld = 1'b0;
  wr_t             exp_q[$];
  wr_t             obs_q[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              exp_cnt = 0;

  always #5 clk = ~clk;

  // grid_row_ram model: sync read, latency 1, plus a bench preload path.
  always @(posedge clk) begin
    if (ld) mem <= img;
    else if (g.wr_en) mem[g.wr_addr] <= g.wr_data;
    g.rd_data <= mem[g.rd_addr];
  end

  always @(negedge clk)
    if (g.wr_en === 1'b1) obs_q.push_back(wr_t'({g.wr_addr, g.wr_data}));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Expected writes and final grid, from the current RAM contents.
  task automatic build_model();
    int dst;
    dst = ROWS - 1;
    exp_q.delete();
    exp_cnt = 0;
    for (int s = ROWS - 1; s >= 0; s--) begin
      if (&mem[s]) exp_cnt++;
      else begin
        if (s != dst) exp_q.push_back(wr_t'({AW'(dst), mem[s]}));
        exp_img[dst] = mem[s];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) begin
      exp_q.push_back(wr_t'({AW'(r), {COLS{1'b0}}}));
      exp_img[r] = '0;
    end
  endtask

  task automatic load_grid();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 1);
  endtask

  // Called one cycle after the done pulse.
  task automatic check_result(input string tag);
    int m;
    chk({tag, "_busy_off"}, 32'(busy), 0);
    chk({tag, "_done_off"}, 32'(done), 0);
    chk({tag, "_lines"}, 32'(lines_cleared), exp_cnt);
    chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
    for (int r = 0; r < ROWS; r++) chk({tag, "_row"}, 32'(mem[r]), 32'(exp_img[r]));
  endtask

  task automatic run_pass(input string tag, input int exp_cycle);
    int n;
    build_model();
    obs_q.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 1);
    chk({tag, "_rd_addr0"}, 32'(g.rd_addr), ROWS - 1);
    wait_done(tag, n);
    chk({tag, "_done_cyc"}, n, (exp_cycle < 0) ? 33 + exp_cnt : exp_cycle);
    @(posedge clk);
    #1;
    check_result(tag);
  endtask

  initial begin
    int n, first_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_lines", 32'(lines_cleared), 0);
    chk("rst_wr_en", 32'(g.wr_en), 0);
    chk("rst_rd_addr", 32'(g.rd_addr), 0);
    chk("rst_wr_addr", 32'(g.wr_addr), 0);
    chk("rst_wr_data", 32'(g.wr_data), 0);
    @(negedge clk) reset = 1'b0;

    // Empty grid: no writes at all.
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    load_grid();
    run_pass("empty", 33);
    chk("empty_nwr0", obs_q.size(), 0);

    // One full row at the bottom.
    img[15] = 16'hFFFF;
    img[14] = 16'h0001;
    load_grid();
    run_pass("one", 34);
    chk("one_row15", 32'(mem[15]), 32'h0001);
    chk("one_row14", 32'(mem[14]), 0);
    chk("one_lines", 32'(lines_cleared), 1);

    // Two full rows interleaved with partial rows.
    for (int r = 0; r < ROWS; r++) img[r] = '0;
    img[15] = 16'hFFFF;
    img[14] = 16'h00F0;
    img[13] = 16'hFFFF;
    img[12] = 16'h0F00;
    load_grid();
    run_pass("two", 35);
    chk("two_row15", 32'(mem[15]), 32'h00F0);
    chk("two_row14", 32'(mem[14]), 32'h0F00);
    chk("two_row13", 32'(mem[13]), 0);
    chk("two_lines", 32'(lines_cleared), 2);

    // Every row full: only the fill writes appear.
    for (int r = 0; r < ROWS; r++) img[r] = '1;
    load_grid();
    run_pass("full", 49);
    chk("full_nwr", obs_q.size(), 16);
    chk("full_lines", 32'(lines_cleared), 16);

    // Reset during cycle 10 of a pass with writes in flight.
    for (int r = 0; r < ROWS; r++) img[r] = r[0] ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
    load_grid();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_wr_en", 32'(g.wr_en), 0);
    chk("mid_lines", 32'(lines_cleared), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_rd_addr", 32'(g.rd_addr), 0);
    @(negedge clk) reset = 1'b0;
    load_grid();
    run_pass("after_rst", -1);

    // Start held high through a whole pass: one pass, then a second after done.
    for (int r = 0; r < ROWS; r++) img[r] = 16'($urandom_range(0, 16'hFFFE));
    img[15] = 16'hFFFF;
    img[10] = 16'hFFFF;
    img[3]  = 16'hFFFF;
    load_grid();
    build_model();
    first_cnt = exp_cnt;
    obs_q.delete();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_busy_rise", 32'(busy), 1);
    wait_done("hold1", n);
    chk("hold1_done_cyc", n, 36);
    @(posedge clk);
    #1;
    check_result("hold1");
    build_model();
    obs_q.delete();
    @(posedge clk);
    #1;
    chk("hold2_busy_rise", 32'(busy), 1);
    chk("hold2_lines_held", 32'(lines_cleared), first_cnt);
    start = 1'b0;
    wait_done("hold2", n);
    chk("hold2_done_cyc", n, 33);
    @(posedge clk);
    #1;
    check_result("hold2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
